// File: rtl/priority_arbiter4_pkg.sv
//----------------------------------------------------------------------
// priority_arbiter4_pkg -- shared types for the 4-way arbiter. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package priority_arbiter4_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/priority_arbiter4_priority_encoder.sv
//----------------------------------------------------------------------
// priority_encoder -- 4-to-2 encoder, highest set bit wins. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module priority_encoder (
  input  logic [3:0] a,
  output logic [1:0] y,
  output logic       valid
);

  always_comb begin
    y     = 2'd0;
    valid = |a;
    if (a[3])      y = 2'd3;
    else if (a[2]) y = 2'd2;
    else if (a[1]) y = 2'd1;
    else           y = 2'd0;
  end

endmodule

`default_nettype wire

// File: rtl/priority_arbiter4.sv
//----------------------------------------------------------------------
// priority_arbiter4 -- fixed/round-robin 4-way arbiter, hold timeout. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module priority_arbiter4
  import priority_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       mode,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [7:0] r_hold_cnt;
  idx_t       r_last_id;

  idx_t       w_shift;
  logic [3:0] w_req_rot;
  idx_t       w_enc_y;
  logic       w_enc_valid;
  idx_t       w_winner;

  // Rotating by last_id puts index last_id-1 at the top of the encoder,
  // so descending priority walks the round-robin order.
  assign w_shift = mode ? r_last_id : 2'd0;

  always_comb begin
    w_req_rot = 4'b0000;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_req_rot[k] = req[2'(k + int'(w_shift))];
    end
  end

  priority_encoder u_enc (
    .y     (w_enc_y),
    .valid (w_enc_valid),
    .a     (w_req_rot)
  );

  assign w_winner = w_enc_y + w_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= 8'd0;
      r_last_id  <= 2'd0;
      grant      <= 4'b0000;
      grant_id   <= 2'd0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_enc_valid) begin
            r_state    <= BUSY;
            r_hold_cnt <= 8'd0;
            r_last_id  <= w_winner;
            grant      <= 4'b0001 << w_winner;
            grant_id   <= w_winner;
            busy       <= 1'b1;
          end else begin
            grant <= 4'b0000;
            busy  <= 1'b0;
          end
        end
        BUSY: begin
          if (done) begin
            r_state <= IDLE;
            grant   <= 4'b0000;
            busy    <= 1'b0;
          end else if (r_hold_cnt == c_hold_last) begin
            r_state <= IDLE;
            grant   <= 4'b0000;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          grant   <= 4'b0000;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_priority_arbiter4.sv
//----------------------------------------------------------------------
// tb_priority_arbiter4 -- vector table, corner sequences, random vs model. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_priority_arbiter4;

  localparam int MAX_HOLD = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       mode = 1'b0;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit m_busy = 1'b0;
  bit m_to   = 1'b0;
  int m_gid  = 0;
  int m_last = 0;
  int m_hold = 0;

  typedef struct {
    logic [3:0] req;
    logic       mode;
    logic       done;
    logic       rst;
    logic [3:0] grant;
    logic       busy;
    logic       tmo;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl[25];

  priority_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .mode     (mode),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [3:0] r, logic m, logic d, logic rs,
                              logic [3:0] g, logic b, logic t, logic [1:0] id);
    vec_t v;
    v.req = r; v.mode = m; v.done = d; v.rst = rs;
    v.grant = g; v.busy = b; v.tmo = t; v.gid = id;
    return v;
  endfunction

  // Winner search straight from the ordering rules
  function automatic int pick(logic [3:0] r, logic m, int last);
    for (int i = 1; i <= 4; i++) begin
      int idx;
      idx = m ? ((last - i + 8) % 4) : (4 - i);
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(logic [3:0] r, logic m, logic d, logic rs);
    int w;
    if (rs) begin
      m_busy = 0; m_to = 0; m_gid = 0; m_last = 0; m_hold = 0;
    end else if (!m_busy) begin
      m_to = 0;
      w = pick(r, m, m_last);
      if (w >= 0) begin
        m_busy = 1; m_gid = w; m_last = w; m_hold = 0;
      end
    end else if (d) begin
      m_busy = 0; m_to = 0;
    end else if (m_hold == MAX_HOLD - 1) begin
      m_busy = 0; m_to = 1;
    end else begin
      m_hold++; m_to = 0;
    end
  endtask

  task automatic apply(logic [3:0] r, logic m, logic d, logic rs);
    @(negedge clk);
    req = r; mode = m; done = d; reset = rs;
    @(posedge clk);
    model_step(r, m, d, rs);
    #1;
  endtask

  task automatic check_val(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    logic [3:0] eg;
    logic [3:0] inv;
    eg = m_busy ? (4'b0001 << m_gid) : 4'b0000;
    vectors++;
    if (grant !== eg || busy !== m_busy || timeout !== m_to ||
        (m_busy && grant_id !== m_gid[1:0])) begin
      miscompares++;
      $display("FAIL %s: grant=%b busy=%b timeout=%b id=%0d, expected grant=%b busy=%b timeout=%b id=%0d",
               tag, grant, busy, timeout, grant_id, eg, m_busy, m_to, m_gid);
    end
    inv = busy ? (4'b0001 << grant_id) : 4'b0000;
    vectors++;
    if (grant !== inv) begin
      miscompares++;
      $display("FAIL %s onehot: grant=%b busy=%b id=%0d, expected grant=%b",
               tag, grant, busy, grant_id, inv);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // req mode done rst | grant busy tmo gid
    tbl[0]  = mk(4'b0110, 0, 0, 1, 4'b0000, 0, 0, 0);
    tbl[1]  = mk(4'b0110, 0, 0, 0, 4'b0100, 1, 0, 2);
    tbl[2]  = mk(4'b0110, 0, 0, 0, 4'b0100, 1, 0, 2);
    tbl[3]  = mk(4'b0110, 0, 0, 0, 4'b0100, 1, 0, 2);
    tbl[4]  = mk(4'b0110, 0, 0, 0, 4'b0100, 1, 0, 2);
    tbl[5]  = mk(4'b0110, 0, 1, 0, 4'b0000, 0, 0, 0);
    tbl[6]  = mk(4'b0110, 0, 0, 0, 4'b0100, 1, 0, 2);
    tbl[7]  = mk(4'b0110, 0, 1, 0, 4'b0000, 0, 0, 0);
    tbl[8]  = mk(4'b1111, 1, 0, 1, 4'b0000, 0, 0, 0);
    tbl[9]  = mk(4'b1111, 1, 0, 0, 4'b1000, 1, 0, 3);
    tbl[10] = mk(4'b1111, 1, 1, 0, 4'b0000, 0, 0, 0);
    tbl[11] = mk(4'b1111, 1, 0, 0, 4'b0100, 1, 0, 2);
    tbl[12] = mk(4'b1111, 1, 1, 0, 4'b0000, 0, 0, 0);
    tbl[13] = mk(4'b1111, 1, 0, 0, 4'b0010, 1, 0, 1);
    tbl[14] = mk(4'b1111, 1, 1, 0, 4'b0000, 0, 0, 0);
    tbl[15] = mk(4'b1111, 1, 0, 0, 4'b0001, 1, 0, 0);
    tbl[16] = mk(4'b1111, 1, 1, 0, 4'b0000, 0, 0, 0);
    tbl[17] = mk(4'b1111, 1, 0, 0, 4'b1000, 1, 0, 3);
    tbl[18] = mk(4'b1111, 1, 0, 1, 4'b0000, 0, 0, 0);
    tbl[19] = mk(4'b1111, 1, 0, 0, 4'b1000, 1, 0, 3);
    tbl[20] = mk(4'b0000, 1, 0, 0, 4'b1000, 1, 0, 3);
    tbl[21] = mk(4'b0000, 1, 1, 0, 4'b0000, 0, 0, 0);
    tbl[22] = mk(4'b0000, 1, 1, 0, 4'b0000, 0, 0, 0);
    tbl[23] = mk(4'b1000, 0, 0, 0, 4'b1000, 1, 0, 3);
    tbl[24] = mk(4'b1000, 0, 1, 0, 4'b0000, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      apply(tbl[i].req, tbl[i].mode, tbl[i].done, tbl[i].rst);
      vectors++;
      if (grant !== tbl[i].grant || busy !== tbl[i].busy || timeout !== tbl[i].tmo ||
          ((tbl[i].busy || tbl[i].rst) && grant_id !== tbl[i].gid)) begin
        miscompares++;
        $display("FAIL table[%0d]: grant=%b busy=%b timeout=%b id=%0d, expected grant=%b busy=%b timeout=%b id=%0d",
                 i, grant, busy, timeout, grant_id,
                 tbl[i].grant, tbl[i].busy, tbl[i].tmo, tbl[i].gid);
      end
    end

    // Forced release after MAX_HOLD cycles, then re-grant after one idle cycle
    apply(4'b0000, 0, 0, 1);
    for (int c = 1; c <= MAX_HOLD + 2; c++) begin
      apply(4'b0001, 0, 0, 0);
      check_model("timeout_seq");
      if (c == MAX_HOLD)     check_val("held_last_cycle_grant", int'(grant), 1);
      if (c == MAX_HOLD + 1) check_val("timeout_pulse", int'({grant, timeout}), 1);
      if (c == MAX_HOLD + 2) check_val("regrant_after_timeout", int'({grant, timeout}), 2);
    end

    // done coincident with the timeout condition releases normally
    apply(4'b0000, 0, 0, 1);
    for (int c = 1; c <= MAX_HOLD + 2; c++) begin
      apply(4'b0001, 0, (c == MAX_HOLD + 1), 0);
      check_model("done_at_limit");
      if (c == MAX_HOLD + 1) check_val("no_timeout_with_done", int'({grant, busy, timeout}), 0);
    end

    // Every req value in both modes
    apply(4'b0000, 0, 0, 1);
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 16; r++) begin
        apply(4'(r), 1'(m), 0, 0);
        check_model("sweep_grant");
        apply(4'b0000, 1'(m), 1, 0);
        check_model("sweep_release");
        apply(4'b0000, 1'(m), 0, 0);
        check_model("sweep_idle");
      end
    end

    // Random traffic: frequent done, then rare done to reach timeouts
    for (int n = 0; n < 3000; n++) begin
      logic d;
      d = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      apply(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), d,
            ($urandom_range(0, 99) == 0));
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/priority_arbiter4.md
PRIORITY_ARBITER4 -- requirements
Module: priority_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 15, meaning: maximum cycles a grant is held without done before forced release (legal range 2..255).
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  request vector, req[i] from requester i, level-sensitive.
REQ-005 mode  input  1  0 = fixed priority (req[3] highest), 1 = round-robin.
REQ-006 done  input  1  current owner releases the resource, single-cycle pulse.
REQ-007 grant  output  4  one-hot grant to current owner, all-zero when idle.
REQ-008 grant_id  output  2  binary index of current owner, valid only while busy=1.
REQ-009 busy  output  1  high while any grant is active.
REQ-010 timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-011 The FSM has two states, IDLE and BUSY; all outputs are registered.
REQ-012 IDLE, req != 0 at a clock edge -> BUSY; next cycle grant, grant_id and busy reflect the winner (latency 1 cycle).
REQ-013 IDLE, req == 0 -> stay IDLE, grant = 0, busy = 0.
REQ-014 Fixed mode: winner is the highest-index asserted req bit (priority-encoder order 3,2,1,0).
REQ-015 Round-robin mode: search order starts at (last_id-1) mod 4 and descends cyclically, ending at last_id; e.g. last_id=2 -> order 1,0,3,2.
REQ-016 last_id is a 2-bit register, updated to the winner's index on every IDLE->BUSY transition in either mode.
REQ-017 mode is sampled only at the arbitration edge; changes during BUSY have no effect on the current grant.
REQ-018 BUSY with done=1 -> IDLE; grant, busy clear the following cycle.
REQ-019 Minimum one IDLE cycle between consecutive grants; no back-to-back re-arbitration.
REQ-020 Deasserting the owner's req during BUSY does not release the grant; only done or timeout releases.
REQ-021 A hold counter (8 bits) clears on entry to BUSY and increments each BUSY cycle.
REQ-022 BUSY, counter == MAX_HOLD-1, done=0 -> IDLE and timeout=1 for exactly the next cycle, grant cleared that same cycle.
REQ-023 done=1 on the same cycle as the timeout condition: normal release, timeout stays 0.
REQ-024 done while IDLE is ignored.
REQ-025 grant is always one-hot or zero; grant == (busy ? 1<<grant_id : 0).

Reset
REQ-026 reset=1 at a clock edge forces IDLE, grant=0, grant_id=0, busy=0, timeout=0, counter=0, last_id=0, regardless of state.
REQ-027 reset mid-grant drops the grant on the next cycle with no timeout pulse; first post-reset round-robin order is 3,2,1,0.

Structure
REQ-028 A shared package holds the state enum (IDLE, BUSY), NUM_REQ=4 and the 2-bit index typedef.
REQ-029 The winner selection instantiates the existing 4-to-2 priority_encoder (y, valid, a) as the single sub-module; round-robin is done by rotating req before it and un-rotating its y after it.
REQ-030 Target size 120-400 lines RTL, no latches, no multicycle paths.

Verification
REQ-031 Fixed mode, req=4'b0110 held, done after 3 cycles -> grant=4'b0100, grant_id=2 one cycle after request, busy 4 cycles, then 1 idle cycle, then grant=4'b0100 again.
REQ-032 RR mode from reset, req=4'b1111 held, done 1 cycle after each grant -> grant_id sequence 3,2,1,0,3.
REQ-033 MAX_HOLD=15, req=4'b0001, no done -> grant held 15 cycles, then grant=0 with timeout=1 for one cycle, re-grant after one idle cycle.
REQ-034 done and timeout coincident on cycle 15 -> release with timeout=0.
REQ-035 Reset asserted while grant=4'b1000 -> next cycle all outputs 0, last_id=0; owner req dropped mid-grant alone -> grant stays.
REQ-036 Every cycle assert grant one-hot/zero and consistent with grant_id and busy; all 16 req values exercised in both modes against a reference order model.
